// File: rtl/pixel_stream_to_axis.sv
// Pixel stream to AXI4-Stream bridge.
// A non-stallable pixel source (data_enable/frame_start/line_end) is framed by
// a small input FSM and buffered in a FIFO whose head entry drives the AXIS
// master. On overflow the rest of the frame is dropped until the next frame_start.
module pixel_stream_to_axis #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        frame_start,
  input  logic        line_end,
  input  logic        data_enable,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        overflow,
  input  logic        overflow_clear,
  output logic [15:0] frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW + 1)'(DEPTH);

  localparam logic [1:0] S_WAIT_SOF = 2'd0;
  localparam logic [1:0] S_ACTIVE   = 2'd1;
  localparam logic [1:0] S_DROP     = 2'd2;

  logic [1:0]    r_state;
  logic          r_pend_sof;
  logic          r_overflow;
  logic [15:0]   r_frame_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [9:0]    r_mem [DEPTH];

  logic          w_full;
  logic          w_in_active;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_valid;
  logic [9:0]    w_head;

  // Full looks only at the registered occupancy, so a same-cycle pop never frees room.
  assign w_full      = (r_count == LP_FULL);
  assign w_in_active = (r_state == S_ACTIVE);
  assign w_push      = w_in_active && data_enable && !w_full;
  assign w_drop      = w_in_active && data_enable && w_full;
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid && m_axis_tready;
  assign w_head      = r_mem[r_rd_ptr];

  // Head of the FIFO is presented directly; zeroed while empty so idle outputs are clean.
  assign m_axis_tvalid = w_valid;
  assign m_axis_tdata  = w_valid ? w_head[7:0] : 8'd0;
  assign m_axis_tlast  = w_valid ? w_head[8]   : 1'b0;
  assign m_axis_tuser  = w_valid ? w_head[9]   : 1'b0;
  assign overflow      = r_overflow;
  assign frame_count   = r_frame_count;

  // Input framing FSM: wait for a frame, accept it, or discard until the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_WAIT_SOF;
      r_pend_sof <= 1'b0;
    end else begin
      case (r_state)
        S_ACTIVE: begin
          // A new frame_start re-arms SOF; otherwise the first write consumes it.
          if (frame_start)
            r_pend_sof <= 1'b1;
          else if (w_push)
            r_pend_sof <= 1'b0;
          if (w_drop && !frame_start)
            r_state <= S_DROP;
        end
        S_WAIT_SOF, S_DROP: begin
          if (frame_start) begin
            r_pend_sof <= 1'b1;
            r_state    <= S_ACTIVE;
          end
        end
        default: r_state <= S_WAIT_SOF;
      endcase
    end
  end

  // Sticky overflow flag; a new drop wins over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_overflow <= 1'b0;
    else if (w_drop)
      r_overflow <= 1'b1;
    else if (overflow_clear)
      r_overflow <= 1'b0;
  end

  // Counts frames whose first beat actually entered the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_frame_count <= 16'd0;
    else if (w_push && r_pend_sof)
      r_frame_count <= r_frame_count + 16'd1;
  end

  // FIFO pointers and occupancy (0..DEPTH inclusive, pointers wrap modulo DEPTH).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage, word = {sof, eol, pixel}; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {r_pend_sof, line_end, data};
  end

endmodule

// File: doc/pixel_stream_to_axis.md
PIXEL_STREAM_TO_AXIS -- requirements
Module: pixel_stream_to_axis

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO depth in beats; a power of two, minimum 4.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port data  input  8  pixel value from the fractal generator.
REQ-005 The block SHALL have port frame_start  input  1  one-cycle pulse marking the start of a frame.
REQ-006 The block SHALL have port line_end  input  1  qualifies the last pixel of a line; valid only with data_enable.
REQ-007 The block SHALL have port data_enable  input  1  pixel valid; the source cannot be stalled.
REQ-008 The block SHALL have port m_axis_tdata  output  8  pixel out.
REQ-009 The block SHALL have port m_axis_tvalid  output  1  output beat valid.
REQ-010 The block SHALL have port m_axis_tready  input  1  downstream ready.
REQ-011 The block SHALL have port m_axis_tuser  output  1  start of frame, set on the first pixel of a frame only.
REQ-012 The block SHALL have port m_axis_tlast  output  1  end of line.
REQ-013 The block SHALL have port overflow  output  1  sticky FIFO-overflow flag.
REQ-014 The block SHALL have port overflow_clear  input  1  one-cycle pulse that clears overflow.
REQ-015 The block SHALL have port frame_count  output  16  count of frames started in the FIFO; wraps 0xFFFF->0.

Function
REQ-016 The input state machine SHALL have three states: WAIT_SOF, ACTIVE and DROP.
REQ-017 In WAIT_SOF, a frame_start pulse SHALL set a pending-SOF bit and move the FSM to ACTIVE; all data_enable beats are discarded in WAIT_SOF, including one coincident with frame_start.
REQ-018 In ACTIVE, each data_enable beat SHALL be written to the FIFO as {sof=pending-SOF, eol=line_end, data}; pending-SOF clears on the first write.
REQ-019 Each data_enable beat in ACTIVE SHALL be written only if the FIFO is not full.
REQ-020 frame_count SHALL increment on every write with sof=1.
REQ-021 Full SHALL be evaluated on the registered occupancy only: a same-cycle pop does not make room for a push.
REQ-022 A data_enable beat in ACTIVE with the FIFO full SHALL be dropped, set overflow, and move the FSM to DROP.
REQ-023 In DROP, all beats SHALL be discarded; the next frame_start sets pending-SOF and moves the FSM to ACTIVE, so a corrupted frame is never partially forwarded beyond the drop point.
REQ-024 A frame_start while in ACTIVE SHALL re-arm pending-SOF; the next written beat then carries sof=1, even if the previous frame was short.
REQ-025 A line_end without data_enable SHALL be ignored.
REQ-026 The output SHALL be driven from a registered FIFO read: a beat written in cycle N SHALL be visible on m_axis_tvalid no earlier than cycle N+1.
REQ-027 With the FIFO empty and m_axis_tready=1, a beat written in cycle N SHALL appear on m_axis_tvalid in cycle N+1.
REQ-028 A pop SHALL occur when m_axis_tvalid and m_axis_tready are both 1.
REQ-029 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tuser and m_axis_tlast SHALL be held stable.
REQ-030 With continuous tready, the block SHALL sustain one beat per cycle.
REQ-031 m_axis_tuser and m_axis_tlast SHALL come directly from the stored sof and eol bits.
REQ-032 If overflow_clear and a new overflow event occur in the same cycle, overflow SHALL remain 1 (set wins).
REQ-033 Read and write pointers SHALL wrap modulo DEPTH; occupancy is tracked from 0 to DEPTH inclusive.

Reset
REQ-034 While reset=1, the block SHALL force: FSM=WAIT_SOF, FIFO empty, pending-SOF=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, overflow=0, frame_count=0.
REQ-035 An assertion of reset mid-frame SHALL discard all buffered beats immediately.
REQ-036 After reset is released, the block SHALL ignore all input until the next frame_start.

Verification
REQ-037 A bench SHALL cover: reset, frame_start, then 4x3 pixels with data 0..11 and line_end on 3/7/11, tready=1 -> 12 beats in order; tuser on beat 0 only; tlast on beats 3, 7 and 11; frame_count=1.
REQ-038 A bench SHALL cover: tready=0 with DEPTH=16 and 20 pixels -> 16 stored, overflow=1, FSM in DROP; after tready=1, exactly 16 beats out; beats up to the next frame_start are discarded; the next frame starts with tuser=1.
REQ-039 A bench SHALL cover: data_enable beats before the first frame_start -> no output and frame_count=0.
REQ-040 A bench SHALL cover: tready toggling every cycle during a 384-pixel line -> no loss, data stable during stalls, exactly one tlast.
REQ-041 A bench SHALL cover: reset asserted with 5 beats buffered -> m_axis_tvalid=0 next edge; after release and frame_start, the first output beat has tuser=1.
REQ-042 A bench SHALL cover: overflow_clear coincident with a new overflow drop -> overflow stays 1; overflow_clear alone -> overflow=0 the next cycle.
